// File: rtl/perceptron_weight_table_bf_v2_pkg.sv
// Shared definitions for the bias-free perceptron weight table.
//   - Default sizing constants for lanes, depth, index and weight widths.
//   - weight_t / index_t typedefs used by the top and the lane sub-module.
//   - sat_step(): one saturating +/-1 step on a signed weight.
//   - table_state_e: CLEAR (reset sweep) / RUN (normal operation).
package bf_pred_pkg;

  localparam int NUM_LANES_DEF = 48;
  localparam int DEPTH_DEF     = 32768;
  localparam int INDEX_W_DEF   = 15;
  localparam int WEIGHT_W      = 2;

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef logic [INDEX_W_DEF-1:0]     index_t;

  typedef enum logic {CLEAR, RUN} table_state_e;

  // The step is computed one bit wider than the weight, so the overflowed
  // value is still representable and can be clamped instead of wrapping.
  function automatic weight_t sat_step(weight_t w, logic inc);
    localparam logic signed [WEIGHT_W:0] ONE  = {{WEIGHT_W{1'b0}}, 1'b1};
    localparam logic signed [WEIGHT_W:0] WMAX = {2'b00, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W:0] WMIN = {2'b11, {(WEIGHT_W-1){1'b0}}};
    logic signed [WEIGHT_W:0] ext;
    logic signed [WEIGHT_W:0] nxt;
    ext = {w[WEIGHT_W-1], w};
    nxt = inc ? (ext + ONE) : (ext - ONE);
    if (nxt > WMAX)      nxt = WMAX;
    else if (nxt < WMIN) nxt = WMIN;
    return weight_t'(nxt[WEIGHT_W-1:0]);
  endfunction

endpackage

// File: rtl/perceptron_weight_table_bf_v2_if.sv
// Request/response bundle of the weight table.
//   master : predictor pipeline (drives pred/upd requests, reads weights)
//   slave  : the weight table itself
// Signals: init_done, pred_valid/pred_index, pred_weights_valid/pred_weights,
//          upd_valid/upd_index/upd_lane_en/upd_inc (lane i at slice i).
interface perceptron_weight_table_bf_v2_if #(
  parameter int NUM_LANES = 48,
  parameter int INDEX_W   = 15,
  parameter int WEIGHT_W  = 2
);
  logic                          init_done;
  logic                          pred_valid;
  logic [NUM_LANES*INDEX_W-1:0]  pred_index;
  logic                          pred_weights_valid;
  logic [NUM_LANES*WEIGHT_W-1:0] pred_weights;
  logic                          upd_valid;
  logic [NUM_LANES*INDEX_W-1:0]  upd_index;
  logic [NUM_LANES-1:0]          upd_lane_en;
  logic [NUM_LANES-1:0]          upd_inc;

  modport master (
    input  init_done, pred_weights_valid, pred_weights,
    output pred_valid, pred_index, upd_valid, upd_index, upd_lane_en, upd_inc
  );

  modport slave (
    output init_done, pred_weights_valid, pred_weights,
    input  pred_valid, pred_index, upd_valid, upd_index, upd_lane_en, upd_inc
  );
endinterface

// File: rtl/perceptron_weight_table_bf_v2_lane.sv
// One weight lane: DEPTH-entry RAM, the two-stage read-modify-write update
// pipeline and the forwarding muxes that let the stage-2 write be seen by
// a same-edge stage-1 read or prediction read.
// Ports:
//   clk, rst_n            clock / async active-low reset (control only)
//   clr_en, clr_idx       clear-sweep write of zero
//   rd_idx -> rd_data     prediction read (combinational, registered by top)
//   upd_vld, upd_idx,
//   upd_en, upd_inc       update request (already gated to RUN by the top)
module perceptron_weight_lane
  import bf_pred_pkg::*;
#(
  parameter int DEPTH   = 32768,
  parameter int INDEX_W = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_en,
  input  logic [INDEX_W-1:0] clr_idx,
  input  logic [INDEX_W-1:0] rd_idx,
  output weight_t            rd_data,
  input  logic               upd_vld,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic               upd_en,
  input  logic               upd_inc
);

  weight_t mem [DEPTH];

  logic               vld_p1;
  logic [INDEX_W-1:0] idx_p1;
  logic               en_p1;
  logic               inc_p1;
  weight_t            old_p1;

  logic    wr_p2;
  weight_t new_p2;
  weight_t upd_old;

  // ---- stage 2: saturating step and write-enable ----
  assign wr_p2  = vld_p1 & en_p1;
  assign new_p2 = sat_step(old_p1, inc_p1);

  // Same-edge forwarding so back-to-back updates accumulate and a
  // prediction that lands on the write edge sees the new weight.
  assign upd_old = (wr_p2 && (idx_p1 == upd_idx)) ? new_p2 : mem[upd_idx];
  assign rd_data = (wr_p2 && (idx_p1 == rd_idx))  ? new_p2 : mem[rd_idx];

  // ---- stage 1: capture request and old weight ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= upd_vld;
  end

  always_ff @(posedge clk) begin
    idx_p1 <= upd_idx;
    en_p1  <= upd_en;
    inc_p1 <= upd_inc;
    old_p1 <= upd_old;
  end

  // ---- RAM write port: clear sweep has priority over updates ----
  always_ff @(posedge clk) begin
    if (clr_en)     mem[clr_idx] <= '0;
    else if (wr_p2) mem[idx_p1]  <= new_p2;
  end

endmodule

// File: rtl/perceptron_weight_table_bf_v2.sv
// Multi-lane weight store for the bias-free neural branch predictor.
// After reset a sweep zeroes every entry (init_done rises DEPTH cycles after
// rst_n releases); then one NUM_LANES-wide prediction read per cycle with
// 1-cycle latency and one pipelined saturating update per cycle.
// Ports:
//   clk   clock, all state on posedge
//   rst_n asynchronous active-low reset
//   bus   slave modport of perceptron_weight_table_bf_v2_if
module perceptron_weight_table_bf_v2
  import bf_pred_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int INDEX_W   = INDEX_W_DEF
) (
  input logic clk,
  input logic rst_n,
  perceptron_weight_table_bf_v2_if.slave bus
);

  table_state_e state_q, state_d;
  logic [INDEX_W-1:0] clr_cnt;
  logic run;
  logic clr_en;
  logic rd_en;
  logic upd_go;

  logic [NUM_LANES*WEIGHT_W-1:0] rd_all;
  logic [NUM_LANES*WEIGHT_W-1:0] weights_q;
  logic                          weights_vld_q;

  // ---- FSM state register and sweep counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      clr_cnt <= '0;
    else if (clr_en) clr_cnt <= clr_cnt + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_cnt == INDEX_W'(DEPTH - 1)) state_d = RUN;
  end

  always_comb begin
    run    = 1'b0;
    clr_en = 1'b0;
    case (state_q)
      CLEAR:   clr_en = 1'b1;
      RUN:     run    = 1'b1;
      default: clr_en = 1'b1;
    endcase
  end

  // Requests arriving during the sweep are dropped, never queued.
  assign rd_en  = bus.pred_valid & run;
  assign upd_go = bus.upd_valid & run;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    weight_t lane_rd;

    perceptron_weight_lane #(
      .DEPTH   (DEPTH),
      .INDEX_W (INDEX_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_en  (clr_en),
      .clr_idx (clr_cnt),
      .rd_idx  (bus.pred_index[i*INDEX_W +: INDEX_W]),
      .rd_data (lane_rd),
      .upd_vld (upd_go),
      .upd_idx (bus.upd_index[i*INDEX_W +: INDEX_W]),
      .upd_en  (bus.upd_lane_en[i]),
      .upd_inc (bus.upd_inc[i])
    );

    assign rd_all[i*WEIGHT_W +: WEIGHT_W] = lane_rd;
  end

  // ---- output register: prediction result, held when idle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_vld_q <= 1'b0;
      weights_q     <= '0;
    end else begin
      weights_vld_q <= rd_en;
      if (rd_en) weights_q <= rd_all;
    end
  end

  assign bus.init_done          = run;
  assign bus.pred_weights_valid = weights_vld_q;
  assign bus.pred_weights       = weights_q;

endmodule

// File: tb/tb_perceptron_weight_table_bf_v2.sv
// Self-checking bench: small table (8 lanes x 16 entries) against an
// array-of-integers model with clamped +/-1 updates.
module tb_perceptron_weight_table_bf_v2;

  localparam int NL = 8;
  localparam int DP = 16;
  localparam int IW = 4;
  localparam int WW = 2;
  localparam int PW = NL * IW;
  localparam int WV = NL * WW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  perceptron_weight_table_bf_v2_if #(.NUM_LANES(NL), .INDEX_W(IW), .WEIGHT_W(WW)) bus ();

  perceptron_weight_table_bf_v2 #(.NUM_LANES(NL), .DEPTH(DP), .INDEX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int model [NL][DP];
  bit running = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int l = 0; l < NL; l++)
      for (int e = 0; e < DP; e++) model[l][e] = 0;
  endtask

  function automatic logic [PW-1:0] all_idx(input int j);
    logic [IW-1:0] v;
    v = IW'(j);
    return {NL{v}};
  endfunction

  // Drives one cycle of requests and advances the model; pexp is the value
  // a prediction issued in this cycle must return (model before the update).
  task automatic drive_cycle(input logic pv, input logic [PW-1:0] pidx,
                             input logic uv, input logic [PW-1:0] uidx,
                             input logic [NL-1:0] uen, input logic [NL-1:0] uinc,
                             output logic [WV-1:0] pexp);
    int v;
    int ix;
    bus.pred_valid  = pv;
    bus.pred_index  = pidx;
    bus.upd_valid   = uv;
    bus.upd_index   = uidx;
    bus.upd_lane_en = uen;
    bus.upd_inc     = uinc;
    pexp = '0;
    if (running) begin
      for (int l = 0; l < NL; l++) begin
        ix = int'(pidx[l*IW +: IW]);
        v  = model[l][ix];
        pexp[l*WW +: WW] = v[WW-1:0];
      end
      if (uv) begin
        for (int l = 0; l < NL; l++) begin
          if (uen[l]) begin
            ix = int'(uidx[l*IW +: IW]);
            v  = model[l][ix] + (uinc[l] ? 1 : -1);
            if (v > 1)  v = 1;
            if (v < -2) v = -2;
            model[l][ix] = v;
          end
        end
      end
    end
    tick();
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    while (!bus.init_done && cnt < 100) begin
      tick();
      cnt++;
    end
    running = bus.init_done;
  endtask

  task automatic test_reset();
    int cnt;
    logic [WV-1:0] pe;
    running = 0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.init_done !== 1'b0 || bus.pred_weights_valid !== 1'b0 || bus.pred_weights !== '0) begin
      errors++;
      $display("FAIL reset_outputs: init=%b vld=%b w=%h, required 0 0 0",
               bus.init_done, bus.pred_weights_valid, bus.pred_weights);
    end
    model_clear();
    rst_n = 1'b1;
    wait_init(cnt);
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("FAIL init_latency: got %0d cycles, required 16", cnt);
    end
    for (int j = 0; j < DP; j++) begin
      drive_cycle(1'b1, all_idx(j), 1'b0, '0, '0, '0, pe);
      checks++;
      if (bus.pred_weights_valid !== 1'b1 || bus.pred_weights !== pe || pe !== '0) begin
        errors++;
        $display("FAIL init_zero idx %0d: vld=%b w=%h, required 1 %h", j,
                 bus.pred_weights_valid, bus.pred_weights, pe);
      end
    end
    tick();
    checks++;
    if (bus.pred_weights_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got %b, required 0", bus.pred_weights_valid);
    end
  endtask

  task automatic test_saturation();
    logic [WV-1:0] pe;
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, '0, 1'b1, all_idx(5), 8'h01, 8'hFF, pe);
    drive_cycle(1'b1, all_idx(5), 1'b0, '0, '0, '0, pe);
    checks++;
    if (bus.pred_weights !== pe || bus.pred_weights[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL sat_high: got %h, required %h (lane0 +1)", bus.pred_weights, pe);
    end
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, '0, 1'b1, all_idx(5), 8'h01, 8'h00, pe);
    drive_cycle(1'b1, all_idx(5), 1'b0, '0, '0, '0, pe);
    checks++;
    if (bus.pred_weights !== pe || bus.pred_weights[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL sat_low: got %h, required %h (lane0 -2)", bus.pred_weights, pe);
    end
  endtask

  task automatic test_back_to_back();
    logic [WV-1:0] pe;
    // two increments on lane 3 index 7, prediction alongside each
    drive_cycle(1'b1, all_idx(7), 1'b1, all_idx(7), 8'h08, 8'hFF, pe);
    checks++;
    if (bus.pred_weights !== pe || bus.pred_weights[7:6] !== 2'b00) begin
      errors++;
      $display("FAIL b2b_pred_n: got %h, required %h", bus.pred_weights, pe);
    end
    drive_cycle(1'b1, all_idx(7), 1'b1, all_idx(7), 8'h08, 8'hFF, pe);
    checks++;
    if (bus.pred_weights !== pe || bus.pred_weights[7:6] !== 2'b01) begin
      errors++;
      $display("FAIL b2b_pred_n1: got %h, required %h", bus.pred_weights, pe);
    end
    drive_cycle(1'b1, all_idx(7), 1'b0, '0, '0, '0, pe);
    checks++;
    if (bus.pred_weights !== pe || bus.pred_weights[7:6] !== 2'b01) begin
      errors++;
      $display("FAIL b2b_final: got %h, required %h", bus.pred_weights, pe);
    end
    // two back-to-back decrements at index 8 must accumulate to -2
    drive_cycle(1'b0, '0, 1'b1, all_idx(8), 8'h08, 8'h00, pe);
    drive_cycle(1'b0, '0, 1'b1, all_idx(8), 8'h08, 8'h00, pe);
    drive_cycle(1'b1, all_idx(8), 1'b0, '0, '0, '0, pe);
    checks++;
    if (bus.pred_weights !== pe || bus.pred_weights[7:6] !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accumulate: got %h, required %h", bus.pred_weights, pe);
    end
  endtask

  task automatic test_lane_mask();
    logic [WV-1:0] pe;
    drive_cycle(1'b0, '0, 1'b1, all_idx(2), 8'b0000_0101, 8'hFF, pe);
    drive_cycle(1'b1, all_idx(2), 1'b0, '0, '0, '0, pe);
    checks++;
    if (bus.pred_weights !== pe || bus.pred_weights !== 16'h0011) begin
      errors++;
      $display("FAIL lane_mask: got %h, required 0011 (model %h)", bus.pred_weights, pe);
    end
  endtask

  task automatic test_clear_ignore();
    int cnt;
    int bad;
    logic [WV-1:0] pe;
    running = 0;
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.pred_weights !== '0 || bus.pred_weights_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_out: w=%h vld=%b, required 0 0",
               bus.pred_weights, bus.pred_weights_valid);
    end
    model_clear();
    rst_n = 1'b1;
    bad = 0;
    cnt = 0;
    while (!bus.init_done && cnt < 100) begin
      drive_cycle(1'b1, all_idx(cnt % DP), 1'b1, all_idx(cnt % DP), 8'hFF, 8'hFF, pe);
      cnt++;
      if (bus.pred_weights_valid !== 1'b0) bad++;
    end
    running = bus.init_done;
    checks++;
    if (bad !== 0 || cnt !== 16) begin
      errors++;
      $display("FAIL clear_ignore: valid seen %0d times, sweep %0d cycles, required 0 and 16", bad, cnt);
    end
    for (int j = 0; j < DP; j++) begin
      drive_cycle(1'b1, all_idx(j), 1'b0, '0, '0, '0, pe);
      checks++;
      if (bus.pred_weights !== '0 || bus.pred_weights_valid !== 1'b1) begin
        errors++;
        $display("FAIL clear_zero idx %0d: got %h vld=%b, required 0 1", j,
                 bus.pred_weights, bus.pred_weights_valid);
      end
    end
  endtask

  task automatic test_reset_mid_update();
    int cnt;
    logic [WV-1:0] pe;
    drive_cycle(1'b0, '0, 1'b1, all_idx(9), 8'hFF, 8'h00, pe);
    // now in cycle N+1 with the write pending at the coming edge
    running = 0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_clear();
    wait_init(cnt);
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("FAIL mid_reset_latency: got %0d cycles, required 16", cnt);
    end
    drive_cycle(1'b1, all_idx(9), 1'b0, '0, '0, '0, pe);
    checks++;
    if (bus.pred_weights !== '0 || bus.pred_weights !== pe) begin
      errors++;
      $display("FAIL mid_reset_entry: got %h, required 0", bus.pred_weights);
    end
  endtask

  task automatic test_random();
    logic [WV-1:0] pe;
    logic [WV-1:0] held;
    logic [PW-1:0] pidx, uidx;
    logic pv, uv;
    logic [NL-1:0] uen, uinc;
    held = bus.pred_weights;
    for (int c = 0; c < 300; c++) begin
      pv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 1));
      uen  = NL'($urandom);
      uinc = NL'($urandom);
      for (int l = 0; l < NL; l++) begin
        pidx[l*IW +: IW] = IW'($urandom_range(0, 3));
        uidx[l*IW +: IW] = IW'($urandom_range(0, 3));
      end
      drive_cycle(pv, pidx, uv, uidx, uen, uinc, pe);
      if (pv) held = pe;
      checks++;
      if (bus.pred_weights_valid !== pv || bus.pred_weights !== held) begin
        errors++;
        $display("FAIL random cyc %0d: vld=%b w=%h, required %b %h", c,
                 bus.pred_weights_valid, bus.pred_weights, pv, held);
      end
    end
  endtask

  initial begin
    bus.pred_valid  = 1'b0;
    bus.pred_index  = '0;
    bus.upd_valid   = 1'b0;
    bus.upd_index   = '0;
    bus.upd_lane_en = '0;
    bus.upd_inc     = '0;
    test_reset();
    test_saturation();
    test_back_to_back();
    test_lane_mask();
    test_random();
    test_clear_ignore();
    test_reset_mid_update();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
